// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock controller.
//   lock_state_e : controller FSM states
//   KEY_*        : keypad event codes that are not digits
//   BLINK_*      : blink request types understood by the LED blinker
package lock_pkg;

    typedef enum logic [2:0] {
        LOCKED     = 3'd0,
        UNLOCKED   = 3'd1,
        PROG_ENTRY = 3'd2,
        BLINK_REQ  = 3'd3,
        BLINK_ACK  = 3'd4,
        BLINK_WAIT = 3'd5,
        LOCKOUT    = 3'd6
    } lock_state_e;

    localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
    localparam logic [3:0] KEY_ENTER     = 4'hA;
    localparam logic [3:0] KEY_CLEAR     = 4'hB;
    localparam logic [3:0] KEY_PROGRAM   = 4'hC;

    localparam logic BLINK_ERROR   = 1'b0;
    localparam logic BLINK_PROG_OK = 1'b1;

    // True for keypad codes 0-9.
    function automatic logic is_digit(input logic [3:0] k);
        return (k <= KEY_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/code_entry_buf.sv
// Digit entry buffer: shifts digits into the LS nibble and counts them.
// Ports:
//   hwclk, reset : clock, synchronous active-high reset
//   clear        : zero buffer, count and overflow (wins over shift)
//   shift, digit : shift one 4-bit digit into the LS nibble
//   code         : buffer contents, first digit entered ends up in the MS nibble
//   count        : digits entered, saturating at CODE_LEN+1
//   overflow     : set once more than CODE_LEN digits have been entered
module code_entry_buf
    import lock_pkg::*;
#(
    parameter int unsigned CODE_LEN = 4,
    localparam int unsigned CODE_W  = 4 * CODE_LEN,
    localparam int unsigned CNT_W   = $clog2(CODE_LEN + 2)
) (
    input  logic              hwclk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic [3:0]        digit,
    output logic [CODE_W-1:0] code,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CODE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CODE_LEN);

    // Shift register plus saturating counter; overflow tracks count == CODE_LEN+1.
    always_ff @(posedge hwclk) begin
        if (reset || clear) begin
            code     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (shift) begin
            code <= {code[CODE_W-5:0], digit};
            if (count != CNT_SAT) begin
                count <= count + CNT_W'(1);
            end
            if (count == CNT_FULL) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lock_controller.sv
// Keypad lock FSM: checks entered codes, drives unlock, supports reprogramming
// the code while unlocked, and requests error / programming-success blinks
// from the LED blinker over a start/done handshake.
// Ports:
//   hwclk, reset        : clock, synchronous active-high reset
//   key_valid, key_code : decoded keypad event (one-cycle pulse)
//   start_blinking      : one-cycle blink request pulse
//   blink_type          : 0 = error blink, 1 = programming-success blink
//   done_blinking       : blinker idle flag (1 = idle)
//   unlocked            : high in UNLOCKED / PROG_ENTRY
//   locked_out          : high during lockout
module lock_controller
    import lock_pkg::*;
#(
    parameter int unsigned              CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0]    DEFAULT_CODE   = (4*CODE_LEN)'(16'h1234),
    parameter int unsigned              MAX_FAILS      = 3,
    parameter logic [31:0]              LOCKOUT_CYCLES = 32'd120000000,
    parameter logic [31:0]              ACK_TIMEOUT    = 32'd1200
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       start_blinking,
    output logic       blink_type,
    input  logic       done_blinking,
    output logic       unlocked,
    output logic       locked_out
);

    localparam int unsigned CODE_W = 4 * CODE_LEN;
    localparam int unsigned CNT_W  = $clog2(CODE_LEN + 2);
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);

    lock_state_e       state, state_next, resume_state;
    logic [CODE_W-1:0] code_reg;
    logic [FAIL_W-1:0] fail_cnt;
    logic [31:0]       timer;
    logic              resume_prog, resume_prog_next;
    logic              blink_type_next;

    logic              buf_clear, buf_clear_key, buf_shift, buf_overflow;
    logic [CODE_W-1:0] buf_code;
    logic [CNT_W-1:0]  buf_count;

    logic key_digit, key_enter, key_clear, key_program;
    logic len_ok, code_match;
    logic code_load, fail_inc, fail_clr, timer_inc;

    assign key_digit   = key_valid && is_digit(key_code);
    assign key_enter   = key_valid && (key_code == KEY_ENTER);
    assign key_clear   = key_valid && (key_code == KEY_CLEAR);
    assign key_program = key_valid && (key_code == KEY_PROGRAM);

    assign len_ok     = (buf_count == CNT_W'(CODE_LEN)) && !buf_overflow;
    assign code_match = len_ok && (buf_code == code_reg);

    // Where a blink sequence returns to once the blinker is done (or never answered).
    always_comb begin
        resume_state = LOCKED;
        if (resume_prog) begin
            resume_state = UNLOCKED;
        end else if (fail_cnt == FAIL_MAX) begin
            resume_state = LOCKOUT;
        end
    end

    code_entry_buf #(
        .CODE_LEN (CODE_LEN)
    ) u_entry_buf (
        .hwclk    (hwclk),
        .reset    (reset),
        .clear    (buf_clear),
        .shift    (buf_shift),
        .digit    (key_code),
        .code     (buf_code),
        .count    (buf_count),
        .overflow (buf_overflow)
    );

    // State register.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            state <= LOCKED;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next       = state;
        buf_shift        = 1'b0;
        buf_clear_key    = 1'b0;
        code_load        = 1'b0;
        fail_inc         = 1'b0;
        fail_clr         = 1'b0;
        timer_inc        = 1'b0;
        blink_type_next  = blink_type;
        resume_prog_next = resume_prog;

        case (state)
            LOCKED: begin
                if (key_digit) begin
                    buf_shift = 1'b1;
                end else if (key_enter) begin
                    if (code_match) begin
                        state_next = UNLOCKED;
                        fail_clr   = 1'b1;
                    end else begin
                        state_next       = BLINK_REQ;
                        fail_inc         = 1'b1;
                        blink_type_next  = BLINK_ERROR;
                        resume_prog_next = 1'b0;
                    end
                end else if (key_clear) begin
                    buf_clear_key = 1'b1;
                end
            end
            UNLOCKED: begin
                if (key_program) begin
                    state_next = PROG_ENTRY;
                end else if (key_enter || key_clear) begin
                    state_next = LOCKED;
                end
            end
            PROG_ENTRY: begin
                if (key_digit) begin
                    buf_shift = 1'b1;
                end else if (key_enter) begin
                    state_next       = BLINK_REQ;
                    resume_prog_next = 1'b1;
                    code_load        = len_ok;
                    blink_type_next  = len_ok ? BLINK_PROG_OK : BLINK_ERROR;
                end else if (key_clear) begin
                    state_next = UNLOCKED;
                end
            end
            BLINK_REQ: begin
                state_next = BLINK_ACK;
            end
            BLINK_ACK: begin
                // A blinker that never leaves idle must not hang the lock.
                if (!done_blinking) begin
                    state_next = BLINK_WAIT;
                end else if (timer == ACK_TIMEOUT - 32'd1) begin
                    state_next = resume_state;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            BLINK_WAIT: begin
                if (done_blinking) begin
                    state_next = resume_state;
                end
            end
            LOCKOUT: begin
                if (timer == LOCKOUT_CYCLES - 32'd1) begin
                    state_next = LOCKED;
                    fail_clr   = 1'b1;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: begin
                state_next = LOCKED;
            end
        endcase

        // Every state change starts from an empty entry buffer.
        buf_clear = buf_clear_key || (state_next != state);
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            code_reg       <= DEFAULT_CODE;
            fail_cnt       <= '0;
            timer          <= '0;
            resume_prog    <= 1'b0;
            blink_type     <= BLINK_ERROR;
            start_blinking <= 1'b0;
            unlocked       <= 1'b0;
            locked_out     <= 1'b0;
        end else begin
            if (code_load) begin
                code_reg <= buf_code;
            end
            if (fail_clr) begin
                fail_cnt <= '0;
            end else if (fail_inc && (fail_cnt != FAIL_MAX)) begin
                fail_cnt <= fail_cnt + FAIL_W'(1);
            end
            timer          <= timer_inc ? (timer + 32'd1) : 32'd0;
            resume_prog    <= resume_prog_next;
            // blink_type is loaded on entry to BLINK_REQ, so it leads the pulse by a cycle.
            blink_type     <= blink_type_next;
            start_blinking <= (state == BLINK_REQ);
            unlocked       <= (state_next == UNLOCKED) || (state_next == PROG_ENTRY);
            locked_out     <= (state_next == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: stimulus queues expected output events
// (unlock edges, lockout edges with duration, blink pulses with type); a monitor
// pops and compares whenever the DUT shows one. A simple blinker model answers
// blink requests.
module tb_lock_controller;
    import lock_pkg::*;

    logic       hwclk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start_blinking;
    logic       blink_type;
    logic       done_blinking;
    logic       unlocked;
    logic       locked_out;

    always #5 hwclk = ~hwclk;

    lock_controller #(
        .LOCKOUT_CYCLES (32'd100),
        .ACK_TIMEOUT    (32'd10)
    ) dut (
        .hwclk          (hwclk),
        .reset          (reset),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .start_blinking (start_blinking),
        .blink_type     (blink_type),
        .done_blinking  (done_blinking),
        .unlocked       (unlocked),
        .locked_out     (locked_out)
    );

    typedef enum int {EV_UNLOCK = 0, EV_LOCKOUT = 1, EV_BLINK = 2} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        logic     val;
        int       dur;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  blinker_en = 1'b1;
    bit  exp_unl = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input ev_kind_e k, input logic v, input int d = 0);
        exp_q.push_back('{k, v, d});
        if (k == EV_UNLOCK) exp_unl = v;
    endtask

    task automatic observe(input ev_kind_e k, input logic v, input int d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d val %0d expected none at %0t",
                     int'(k), v, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            check("event_val", int'(v), int'(e.val));
            if (k == EV_LOCKOUT && !v) check("lockout_len", d, e.dur);
        end
    endtask

    // Monitor: samples on the falling edge.
    logic prev_unl = 1'b0;
    logic prev_lo  = 1'b0;
    int   lo_cnt   = 0;
    initial begin
        forever begin
            @(negedge hwclk);
            if (unlocked !== prev_unl) observe(EV_UNLOCK, unlocked, 0);
            if (locked_out && !prev_lo) begin
                lo_cnt = 0;
                observe(EV_LOCKOUT, 1'b1, 0);
            end
            if (locked_out) lo_cnt++;
            if (!locked_out && prev_lo) observe(EV_LOCKOUT, 1'b0, lo_cnt);
            if (start_blinking) observe(EV_BLINK, blink_type, 0);
            prev_unl = unlocked;
            prev_lo  = locked_out;
        end
    end

    // Blinker model: goes busy 2 cycles after a request, idle again 50 cycles later.
    initial begin
        done_blinking = 1'b1;
        forever begin
            @(negedge hwclk);
            if (start_blinking && blinker_en) begin
                repeat (2) @(posedge hwclk);
                #1 done_blinking = 1'b0;
                repeat (50) @(posedge hwclk);
                #1 done_blinking = 1'b1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        cyc(1);
        key_valid = 1'b0;
        cyc(1);
    endtask

    task automatic digits(input logic [31:0] c, input int n);
        logic [3:0] d;
        for (int i = n - 1; i >= 0; i--) begin
            d = c[4*i +: 4];
            press(d);
        end
    endtask

    task automatic enter_code(input logic [31:0] c, input int n);
        digits(c, n);
        press(KEY_ENTER);
    endtask

    task automatic do_reset();
        if (exp_unl) expect_ev(EV_UNLOCK, 1'b0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_start_blinking"}, int'(start_blinking), 0);
        check({tag, "_blink_type"}, int'(blink_type), 0);
        check({tag, "_unlocked"}, int'(unlocked), 0);
        check({tag, "_locked_out"}, int'(locked_out), 0);
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        cyc(2);
        reset = 1'b0;
        check_outputs_zero("reset");

        // Correct default code unlocks one cycle after ENTER.
        expect_ev(EV_UNLOCK, 1'b1);
        digits(32'h1234, 4);
        check("unlock_before_enter", int'(unlocked), 0);
        key_valid = 1'b1;
        key_code  = KEY_ENTER;
        cyc(1);
        key_valid = 1'b0;
        check("unlock_latency", int'(unlocked), 1);
        cyc(1);

        // Wrong code: one error blink, stays locked.
        do_reset();
        expect_ev(EV_BLINK, BLINK_ERROR);
        enter_code(32'h1235, 4);
        cyc(70);
        check("wrong_code_locked", int'(unlocked), 0);

        // Reprogram to 9876, relock, old code fails, new code unlocks.
        do_reset();
        expect_ev(EV_UNLOCK, 1'b1);
        enter_code(32'h1234, 4);
        expect_ev(EV_UNLOCK, 1'b0);
        expect_ev(EV_BLINK, BLINK_PROG_OK);
        expect_ev(EV_UNLOCK, 1'b1);
        press(KEY_PROGRAM);
        enter_code(32'h9876, 4);
        cyc(70);
        check("prog_ok_unlocked", int'(unlocked), 1);
        expect_ev(EV_UNLOCK, 1'b0);
        press(KEY_ENTER);
        expect_ev(EV_BLINK, BLINK_ERROR);
        enter_code(32'h1234, 4);
        cyc(70);
        expect_ev(EV_UNLOCK, 1'b1);
        enter_code(32'h9876, 4);

        // Three failures -> lockout of 100 cycles; keys ignored meanwhile.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            expect_ev(EV_BLINK, BLINK_ERROR);
            if (i == 2) expect_ev(EV_LOCKOUT, 1'b1);
            enter_code(32'h1111, 4);
            cyc(70);
        end
        expect_ev(EV_LOCKOUT, 1'b0, 100);
        enter_code(32'h1234, 4);
        check("lockout_active", int'(locked_out), 1);
        check("lockout_ignores_code", int'(unlocked), 0);
        cyc(100);
        expect_ev(EV_UNLOCK, 1'b1);
        enter_code(32'h1234, 4);

        // Five digits in LOCKED is an error.
        do_reset();
        expect_ev(EV_BLINK, BLINK_ERROR);
        enter_code(32'h12345, 5);
        cyc(70);
        expect_ev(EV_UNLOCK, 1'b1);
        enter_code(32'h1234, 4);

        // Three digits in PROG_ENTRY: error blink, code unchanged.
        do_reset();
        expect_ev(EV_UNLOCK, 1'b1);
        enter_code(32'h1234, 4);
        expect_ev(EV_UNLOCK, 1'b0);
        expect_ev(EV_BLINK, BLINK_ERROR);
        expect_ev(EV_UNLOCK, 1'b1);
        press(KEY_PROGRAM);
        enter_code(32'h987, 3);
        cyc(70);
        check("short_prog_unlocked", int'(unlocked), 1);
        expect_ev(EV_UNLOCK, 1'b0);
        press(KEY_ENTER);
        expect_ev(EV_UNLOCK, 1'b1);
        enter_code(32'h1234, 4);

        // Blinker never answers: controller returns after the ack timeout.
        do_reset();
        blinker_en = 1'b0;
        expect_ev(EV_BLINK, BLINK_ERROR);
        enter_code(32'h1111, 4);
        cyc(12);
        expect_ev(EV_UNLOCK, 1'b1);
        enter_code(32'h1234, 4);
        blinker_en = 1'b1;

        // Reset during BLINK_WAIT restores the default code and clears outputs.
        do_reset();
        expect_ev(EV_UNLOCK, 1'b1);
        enter_code(32'h1234, 4);
        expect_ev(EV_UNLOCK, 1'b0);
        expect_ev(EV_BLINK, BLINK_PROG_OK);
        press(KEY_PROGRAM);
        enter_code(32'h9876, 4);
        cyc(20);
        check("mid_blink_busy", int'(done_blinking), 0);
        do_reset();
        check_outputs_zero("reset_in_wait");
        cyc(60);
        expect_ev(EV_UNLOCK, 1'b1);
        enter_code(32'h1234, 4);

        cyc(5);
        check("events_outstanding", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
